qar_mem_arbiter: RTL
====================

# qar_mem_arbiter

Two-port round-robin arbiter that shares the single QAR-Core memory port (`mem_addr`/`mem_wdata`/`mem_we`/`mem_rdata`) between the instruction-fetch requester and the load/store requester. It sits between the core pipeline and the unified memory. It issues at most one memory access per cycle and routes each read result back to the requester that issued it. This lets fetch and data traffic contend cleanly instead of being serialised by ad-hoc core logic.

## Interface
Parameters:
- `AW`, 32: address width, byte address.
- `DW`, 32: data width.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `if_req_valid`, in, 1: fetch request valid. Fetch requests are always reads.
- `if_req_ready`, out, 1: fetch request granted this cycle.
- `if_req_addr`, in, AW: fetch address.
- `if_rsp_valid`, out, 1: fetch read data valid; one-cycle pulse.
- `if_rsp_rdata`, out, DW: fetch read data.
- `d_req_valid`, in, 1: data request valid.
- `d_req_ready`, out, 1: data request granted this cycle.
- `d_req_addr`, in, AW: data address.
- `d_req_we`, in, 1: 1 for a store, 0 for a load.
- `d_req_wdata`, in, DW: store data.
- `d_rsp_valid`, out, 1: load data valid; one-cycle pulse. Never asserted for stores.
- `d_rsp_rdata`, out, DW: load data.
- `mem_addr`, out, AW: memory address. Passed through unchanged; word indexing is done by the memory.
- `mem_wdata`, out, DW: memory write data.
- `mem_we`, out, 1: memory write enable.
- `mem_re`, out, 1: memory read enable.
- `mem_rdata`, in, DW: memory read data, valid exactly 1 cycle after a `mem_re` cycle.
- `grant_cnt_if`, out, 16: count of fetch grants, saturating.
- `grant_cnt_d`, out, 16: count of data grants, saturating.

## Operation
- **Request handshake.** A request is accepted in a cycle where `*_req_valid && *_req_ready`. The requester holds its address and data stable while valid is high and ready is low. `*_req_ready` is combinational from the valids and the priority pointer.
- **Arbitration.**
  - Only one requester valid: it is granted immediately.
  - Both valid: the requester not granted most recently wins.
  - Pointer `last_d` (1 = data granted last) updates only on a grant.
  - Reset value `last_d` = 1, so fetch wins the first tie.
- **Memory drive, grant cycle.** On the grant cycle the memory signals are driven combinationally from the winner: `mem_addr`, `mem_we` = winner's write flag (0 for fetch), `mem_re` = winner is a read, `mem_wdata`.
- **Memory drive, idle cycle.** With no grant, `mem_we` = `mem_re` = 0 and `mem_addr`/`mem_wdata` = 0.
- **Response tracking.**
  - On a read grant, register `pend_valid`=1 and `pend_port` = winner (from package constants `QAR_PORT_IF`/`QAR_PORT_D`). Otherwise clear `pend_valid`.
  - Next cycle, the port selected by `pend_port` sees `rsp_valid`=1 and `rsp_rdata` = `mem_rdata`.
  - Both `rsp_rdata` outputs carry `mem_rdata` unconditionally; only the valid bits are gated.
- **Stores.** A store completes at its grant edge and generates no response.
- **Backpressure.** There is none on responses; requesters must accept `rsp_valid` whenever it is asserted.
- **Pipelining.** Back-to-back grants are allowed every cycle, so a read response and a new grant can coincide.
- **Counters.** Each counter increments on its port's grant and saturates at 16'hFFFF.

## Timing
- **Latency.** Grant in cycle N. Read data appears on `*_rsp_valid` in cycle N+1, which is 1 cycle after acceptance. Throughput is 1 access per cycle.
- **Reset values.**
  - `if_rsp_valid`, `d_rsp_valid`, `mem_we`, `mem_re`, `if_req_ready`, `d_req_ready` = 0.
  - Counters, `pend_valid`, `pend_port` = 0.
  - `last_d` = 1.
  - Ready outputs are 0 while `rst_n`=0, regardless of the valids.
- **Reset mid-read.** If `rst_n` is asserted while a read is pending, `pend_valid` clears asynchronously. No response is ever emitted for that read.
- **Simultaneous events.**
  - A response for port X and a new grant to port X in the same cycle are legal.
  - A store by data in cycle N followed by a fetch read of the same address in N+1 returns the new data, because the memory writes at the N edge.
- **Deassertion.** A requester that drops valid before being granted is not recorded and does not move the pointer.

## Structure
- **Shared package `qar_pkg`:**
  - port ID constants `QAR_PORT_IF`=1'b0 and `QAR_PORT_D`=1'b1;
  - `QAR_XLEN`=32, the default for `AW`/`DW`;
  - counter width `QAR_CNT_W`=16.
- **Sub-module `qar_rr_arb2`:** purely combinational 2-way round-robin pick. Inputs are `req[1:0]` and `last`; outputs are one-hot `gnt[1:0]`. The top level owns the pointer register, pending tracker and counters.

## Test plan
- **Fetch-only read.** Reset, then `if_req_valid`=1, addr 0x40, memory model returns 0x00000013 → `if_req_ready`=1 in the same cycle, `mem_re`=1, `mem_addr`=0x40; next cycle `if_rsp_valid`=1 with 0x00000013; `d_rsp_valid` stays 0.
- **Contention.** Both valid continuously for 4 cycles → grants alternate IF, D, IF, D; `grant_cnt_if`=2, `grant_cnt_d`=2; every response lands on the correct port.
- **Store then read.** Data store 0x0000000E to addr 64, then a data load from 64 → no response for the store; the load returns 14 one cycle after its grant; `mem_we` is high only in the store grant cycle.
- **Reset mid-read.** Grant a fetch read, then pull `rst_n` low before the next edge → `if_rsp_valid` never asserts; after release, the first tie is granted to fetch.
- **Counter saturation.** Force 65,537 fetch grants → `grant_cnt_if` holds at 16'hFFFF.
- **Withdrawn request.** Data valid for one cycle while fetch wins, then dropped → no data grant, `last_d` unchanged, no `d_rsp_valid`.

Source files
------------

// File: rtl/qar_pkg.sv
// Shared constants and helpers for the QAR-Core memory arbiter.
// Port IDs double as indices into the arbiter's request/grant vectors.
package qar_pkg;

    localparam int QAR_XLEN  = 32;
    localparam int QAR_CNT_W = 16;

    localparam logic QAR_PORT_IF = 1'b0;
    localparam logic QAR_PORT_D  = 1'b1;

    typedef logic [QAR_CNT_W-1:0] qar_cnt_t;

    // Outstanding read: one slot is enough since memory latency is exactly one cycle.
    typedef struct packed {
        logic valid;
        logic port;
    } qar_pend_t;

    function automatic qar_cnt_t qar_sat_inc(input qar_cnt_t v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/qar_rr_arb2.sv
// Combinational two-way round-robin pick; last=1 means requester 1 won most recently.
module qar_rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt    = 2'b00;
        gnt[0] = req[0] & (~req[1] | last);
        gnt[1] = req[1] & (~req[0] | ~last);
    end

endmodule

// File: rtl/qar_mem_arbiter.sv
// Shares the single QAR-Core memory port between instruction fetch and load/store,
// round-robin on contention, and steers each one-cycle-late read result back to its issuer.
module qar_mem_arbiter
    import qar_pkg::*;
#(
    parameter int AW = QAR_XLEN,
    parameter int DW = QAR_XLEN
) (
    input  logic                 clk,
    input  logic                 rst_n,

    input  logic                 if_req_valid,
    output logic                 if_req_ready,
    input  logic [AW-1:0]        if_req_addr,
    output logic                 if_rsp_valid,
    output logic [DW-1:0]        if_rsp_rdata,

    input  logic                 d_req_valid,
    output logic                 d_req_ready,
    input  logic [AW-1:0]        d_req_addr,
    input  logic                 d_req_we,
    input  logic [DW-1:0]        d_req_wdata,
    output logic                 d_rsp_valid,
    output logic [DW-1:0]        d_rsp_rdata,

    output logic [AW-1:0]        mem_addr,
    output logic [DW-1:0]        mem_wdata,
    output logic                 mem_we,
    output logic                 mem_re,
    input  logic [DW-1:0]        mem_rdata,

    output logic [QAR_CNT_W-1:0] grant_cnt_if,
    output logic [QAR_CNT_W-1:0] grant_cnt_d
);

    logic       last_d_q, last_d_d;
    qar_pend_t  pend_q, pend_d;
    qar_cnt_t   cnt_if_q, cnt_if_d;
    qar_cnt_t   cnt_d_q, cnt_d_d;

    logic [1:0] req;
    logic [1:0] gnt_raw;
    logic [1:0] gnt;
    logic       grant_if;
    logic       grant_d;

    always_comb begin
        req              = 2'b00;
        req[QAR_PORT_IF] = if_req_valid;
        req[QAR_PORT_D]  = d_req_valid;
    end

    qar_rr_arb2 u_arb (
        .req  (req),
        .last (last_d_q),
        .gnt  (gnt_raw)
    );

    // Grants are suppressed while reset is held so nothing reaches memory during reset.
    assign gnt      = gnt_raw & {2{rst_n}};
    assign grant_if = gnt[QAR_PORT_IF];
    assign grant_d  = gnt[QAR_PORT_D];

    assign if_req_ready = grant_if;
    assign d_req_ready  = grant_d;

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        if (grant_if) begin
            mem_addr = if_req_addr;
            mem_re   = 1'b1;
        end else if (grant_d) begin
            mem_addr  = d_req_addr;
            mem_wdata = d_req_wdata;
            mem_we    = d_req_we;
            mem_re    = ~d_req_we;
        end
    end

    always_comb begin
        last_d_d = last_d_q;
        pend_d   = '0;
        cnt_if_d = cnt_if_q;
        cnt_d_d  = cnt_d_q;

        if (grant_if) begin
            last_d_d = 1'b0;
            cnt_if_d = qar_sat_inc(cnt_if_q);
        end
        if (grant_d) begin
            last_d_d = 1'b1;
            cnt_d_d  = qar_sat_inc(cnt_d_q);
        end

        // Stores complete at the grant edge; only reads leave something pending.
        if (mem_re) begin
            pend_d.valid = 1'b1;
            pend_d.port  = grant_d ? QAR_PORT_D : QAR_PORT_IF;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_d_q <= 1'b1;
            pend_q   <= '0;
            cnt_if_q <= '0;
            cnt_d_q  <= '0;
        end else begin
            last_d_q <= last_d_d;
            pend_q   <= pend_d;
            cnt_if_q <= cnt_if_d;
            cnt_d_q  <= cnt_d_d;
        end
    end

    assign if_rsp_valid = pend_q.valid && (pend_q.port == QAR_PORT_IF);
    assign d_rsp_valid  = pend_q.valid && (pend_q.port == QAR_PORT_D);
    assign if_rsp_rdata = mem_rdata;
    assign d_rsp_rdata  = mem_rdata;

    assign grant_cnt_if = cnt_if_q;
    assign grant_cnt_d  = cnt_d_q;

endmodule
